// File: rtl/loop_perf_pkg.sv
// loop_perf_pkg: shared types and helpers for the per-loop performance counter
package loop_perf_pkg;

    localparam int CNT_W_DEF  = 32;
    localparam int ITER_W_DEF = 16;
    localparam int ID_W_DEF   = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } perf_state_e;

    // Default-width record; the top builds a matching struct from its own parameters
    typedef struct packed {
        logic [ID_W_DEF-1:0]   id;
        logic [CNT_W_DEF-1:0]  latency;
        logic [ITER_W_DEF-1:0] iters;
        logic [CNT_W_DEF-1:0]  stalls;
        logic                  unbalanced;
    } loop_perf_rec_t;

    // Increment v by inc, holding at the all-ones value of a w-bit counter
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic inc, input int unsigned w);
        logic [63:0] lim;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (inc && v < lim) ? v + 64'd1 : v;
    endfunction

endpackage

// File: rtl/perf_rec_fifo.sv
// perf_rec_fifo: first-word-fall-through record FIFO with async reset and sync clear
module perf_rec_fifo
    import loop_perf_pkg::*;
#(
    parameter type T     = loop_perf_rec_t,
    parameter int  DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic push_i,
    input  T     wr_data_i,
    input  logic pop_i,
    output T     rd_data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW:0]    wr_q, wr_d, rd_q, rd_d;
    logic           do_push, do_pop;

    // A pop frees the slot a same-cycle push needs, so full+pop still accepts the push
    always_comb begin
        empty_o   = wr_q == rd_q;
        full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop    = pop_i & ~empty_o;
        do_push   = push_i & (~full_o | do_pop);
        wr_d      = do_push ? wr_q + 1'b1 : wr_q;
        rd_d      = do_pop ? rd_q + 1'b1 : rd_q;
        rd_data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
    end

    // Storage needs no reset: the head is masked to zero while empty
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wr_data_i;
    end

    // Read/write pointers with one wrap bit to tell full from empty
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (clear_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

endmodule

// File: rtl/loop_perf_counter.sv
// loop_perf_counter: per-invocation latency/iteration/stall statistics for one HLS loop
module loop_perf_counter
    import loop_perf_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int ITER_W     = 16,
    parameter int ID_W       = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              loop_start,
    input  logic              loop_done,
    input  logic              iter_start,
    input  logic              iter_end,
    input  logic              stall,
    input  logic              clear,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [ID_W-1:0]   rec_id,
    output logic [CNT_W-1:0]  rec_latency,
    output logic [ITER_W-1:0] rec_iters,
    output logic [CNT_W-1:0]  rec_stalls,
    output logic              rec_unbalanced,
    output logic [7:0]        drop_cnt,
    output logic              overflow
);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [CNT_W-1:0]  latency;
        logic [ITER_W-1:0] iters;
        logic [CNT_W-1:0]  stalls;
        logic              unbalanced;
    } rec_t;

    perf_state_e       state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d, next_id_q, next_id_d;
    logic [CNT_W-1:0]  lat_q, lat_d, stalls_q, stalls_d;
    logic [ITER_W-1:0] iters_q, iters_d, starts_q, starts_d;
    logic [7:0]        drop_q, drop_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  lat_acc, stalls_acc;
    logic [ITER_W-1:0] iters_acc, starts_acc, rec_it, rec_st;
    logic              run, open, close_run, push, pop, drop, full, empty;
    rec_t              rec_in, head;

    // Accumulate while running, open on start (from IDLE or back-to-back), close on done
    always_comb begin
        run        = state_q == RUN;
        open       = loop_start & (~run | loop_done);
        close_run  = run & loop_done;
        push       = (close_run | (~run & loop_start & loop_done)) & ~clear;
        lat_acc    = CNT_W'(sat_inc(64'(lat_q), 1'b1, CNT_W));
        stalls_acc = CNT_W'(sat_inc(64'(stalls_q), stall, CNT_W));
        iters_acc  = ITER_W'(sat_inc(64'(iters_q), iter_end, ITER_W));
        starts_acc = ITER_W'(sat_inc(64'(starts_q), iter_start, ITER_W));
        state_d    = ((run & ~loop_done) | (open & (run | ~loop_done))) ? RUN : IDLE;
        lat_d      = open ? CNT_W'(1) : run ? lat_acc : lat_q;
        stalls_d   = open ? CNT_W'(stall) : run ? stalls_acc : stalls_q;
        iters_d    = open ? ITER_W'(iter_end) : run ? iters_acc : iters_q;
        starts_d   = open ? ITER_W'(iter_start) : run ? starts_acc : starts_q;
        id_d       = open ? next_id_q : id_q;
        next_id_d  = open ? next_id_q + 1'b1 : next_id_q;
        rec_it     = close_run ? iters_acc : ITER_W'(iter_end);
        rec_st     = close_run ? starts_acc : ITER_W'(iter_start);
        rec_in.id         = close_run ? id_q : next_id_q;
        rec_in.latency    = close_run ? lat_acc : CNT_W'(1);
        rec_in.iters      = rec_it;
        rec_in.stalls     = close_run ? stalls_acc : CNT_W'(stall);
        rec_in.unbalanced = rec_st != rec_it;
        pop        = ~empty & rec_ready;
        drop       = push & full & ~pop;
        drop_d     = 8'(sat_inc(64'(drop_q), drop, 8));
        ovf_d      = ovf_q | drop;
    end

    // FSM, live counters and drop statistics; clear overrides all other events
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            id_q      <= '0;
            next_id_q <= '0;
            lat_q     <= '0;
            stalls_q  <= '0;
            iters_q   <= '0;
            starts_q  <= '0;
            drop_q    <= '0;
            ovf_q     <= 1'b0;
        end else if (clear) begin
            state_q   <= IDLE;
            id_q      <= '0;
            next_id_q <= '0;
            lat_q     <= '0;
            stalls_q  <= '0;
            iters_q   <= '0;
            starts_q  <= '0;
            drop_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            next_id_q <= next_id_d;
            lat_q     <= lat_d;
            stalls_q  <= stalls_d;
            iters_q   <= iters_d;
            starts_q  <= starts_d;
            drop_q    <= drop_d;
            ovf_q     <= ovf_d;
        end
    end

    perf_rec_fifo #(
        .T     (rec_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (clear),
        .push_i    (push),
        .wr_data_i (rec_in),
        .pop_i     (rec_ready),
        .rd_data_o (head),
        .full_o    (full),
        .empty_o   (empty)
    );

    assign rec_valid      = ~empty;
    assign rec_id         = head.id;
    assign rec_latency    = head.latency;
    assign rec_iters      = head.iters;
    assign rec_stalls     = head.stalls;
    assign rec_unbalanced = head.unbalanced;
    assign drop_cnt       = drop_q;
    assign overflow       = ovf_q;

endmodule
